// File: rtl/cc_frame_if.sv
// Handshake bundle between the serial operand source, the frame collector and the CC block.
// The slave modport is the collector's side of the bundle; the master modport is the opposite side.
interface cc_frame_if #(
  parameter int unsigned DATA_W = 4
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_opt;
  logic              in_equ;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_n0;
  logic [DATA_W-1:0] out_n1;
  logic [DATA_W-1:0] out_n2;
  logic [DATA_W-1:0] out_n3;
  logic [DATA_W-1:0] out_n4;
  logic [DATA_W-1:0] out_n5;
  logic [2:0]        out_opt;
  logic              out_equ;
  logic [7:0]        frame_cnt;
  logic              err_timeout;

  modport slave (
    input  in_valid, in_data, in_opt, in_equ, out_ready,
    output in_ready, out_valid, out_n0, out_n1, out_n2, out_n3, out_n4, out_n5,
           out_opt, out_equ, frame_cnt, err_timeout
  );

  modport master (
    output in_valid, in_data, in_opt, in_equ, out_ready,
    input  in_ready, out_valid, out_n0, out_n1, out_n2, out_n3, out_n4, out_n5,
           out_opt, out_equ, frame_cnt, err_timeout
  );
endinterface

// File: rtl/cc_frame_collector.sv
// Serial-to-parallel operand collector feeding the CC block; holds a full frame until consumed.
// Define CC_COLLECT_TIMEOUT_EN to drop partial frames after TIMEOUT_CYC idle cycles in COLLECT.
module cc_frame_collector #(
  parameter int unsigned NUM_ELEM    = 6,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic        clk,
  input logic        rst,
  cc_frame_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   wr_idx;
  logic [DATA_W-1:0] slot_q [NUM_ELEM];
  logic [2:0]        opt_q;
  logic              equ_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              in_ready;
  logic              accept;
  logic              timeout_hit;

  // CC consumes exactly six operands; a timeout of zero would abort every frame.
  if (NUM_ELEM != 6 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("cc_frame_collector: unsupported NUM_ELEM or TIMEOUT_CYC");
  end

  assign in_ready = (state_q != StHold);
  assign accept   = bus.in_valid & in_ready;
  assign wr_idx   = (state_q == StIdle) ? '0 : idx_q;

`ifdef CC_COLLECT_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);

  logic [GapW-1:0] gap_q, gap_d;
  logic            err_q;

  always_comb begin
    gap_d       = '0;
    timeout_hit = 1'b0;
    if (state_q == StCollect && !accept) begin
      if (gap_q == GapW'(TIMEOUT_CYC - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
      err_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      err_q <= timeout_hit;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = IdxW'(1);
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(NUM_ELEM - 1)) begin
            state_d = StHold;
          end
        end else if (timeout_hit) begin
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slots are never cleared outside reset so a handed-off frame stays readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ELEM; i++) begin
        slot_q[i] <= '0;
      end
      opt_q <= 3'd0;
      equ_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ELEM; i++) begin
        if (accept && wr_idx == IdxW'(i)) begin
          slot_q[i] <= bus.in_data;
        end
      end
      if (accept && state_q == StIdle) begin
        opt_q <= bus.in_opt;
        equ_q <= bus.in_equ;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_n0    = slot_q[0];
  assign bus.out_n1    = slot_q[1];
  assign bus.out_n2    = slot_q[2];
  assign bus.out_n3    = slot_q[3];
  assign bus.out_n4    = slot_q[4];
  assign bus.out_n5    = slot_q[5];
  assign bus.out_opt   = opt_q;
  assign bus.out_equ   = equ_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_cc_frame_collector.sv
// Directed bench for cc_frame_collector: table of frames plus reset, backpressure,
// counter wrap and idle-gap sequences.
module tb_cc_frame_collector;

`ifdef CC_COLLECT_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   nvec;
  int   nfail;

  cc_frame_if #(.DATA_W(4)) bus ();

  cc_frame_collector #(
    .NUM_ELEM   (6),
    .DATA_W     (4),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  d [6];
    logic [2:0]  opt;
    logic        equ;
    int unsigned gap;
    logic [3:0]  e [6];
    logic [2:0]  eopt;
    logic        eequ;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d, input logic [2:0] o, input logic e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_opt   = o;
    bus.in_equ   = e;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'hA;
    bus.in_opt   = 3'b101;
    bus.in_equ   = 1'b1;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [3:0] e [6], input logic [2:0] eopt,
                           input logic eequ);
    chk($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'd1);
    chk($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd0);
    chk($sformatf("%s n0", tag), 32'(bus.out_n0), 32'(e[0]));
    chk($sformatf("%s n1", tag), 32'(bus.out_n1), 32'(e[1]));
    chk($sformatf("%s n2", tag), 32'(bus.out_n2), 32'(e[2]));
    chk($sformatf("%s n3", tag), 32'(bus.out_n3), 32'(e[3]));
    chk($sformatf("%s n4", tag), 32'(bus.out_n4), 32'(e[4]));
    chk($sformatf("%s n5", tag), 32'(bus.out_n5), 32'(e[5]));
    chk($sformatf("%s opt", tag), 32'(bus.out_opt), 32'(eopt));
    chk($sformatf("%s equ", tag), 32'(bus.out_equ), 32'(eequ));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp6 [6];
    nvec          = 0;
    nfail         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_opt    = 3'd0;
    bus.in_equ    = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0].d = '{4'd9, 4'd0, 4'd15, 4'd3, 4'd7, 4'd1};
    vecs[0].opt = 3'b011; vecs[0].equ = 1'b1; vecs[0].gap = 0;
    vecs[0].e = '{4'd9, 4'd0, 4'd15, 4'd3, 4'd7, 4'd1};
    vecs[0].eopt = 3'b011; vecs[0].eequ = 1'b1; vecs[0].ecnt = 8'd1;
    vecs[1].d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    vecs[1].opt = 3'b100; vecs[1].equ = 1'b0; vecs[1].gap = 1;
    vecs[1].e = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    vecs[1].eopt = 3'b100; vecs[1].eequ = 1'b0; vecs[1].ecnt = 8'd2;
    vecs[2].d = '{4'd15, 4'd14, 4'd0, 4'd8, 4'd7, 4'd2};
    vecs[2].opt = 3'b111; vecs[2].equ = 1'b1; vecs[2].gap = 3;
    vecs[2].e = '{4'd15, 4'd14, 4'd0, 4'd8, 4'd7, 4'd2};
    vecs[2].eopt = 3'b111; vecs[2].eequ = 1'b1; vecs[2].ecnt = 8'd3;
    vecs[3].d = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    vecs[3].opt = 3'b000; vecs[3].equ = 1'b0; vecs[3].gap = 2;
    vecs[3].e = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    vecs[3].eopt = 3'b000; vecs[3].eequ = 1'b0; vecs[3].ecnt = 8'd4;

    #12 rst = 1'b0;
    tick();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("reset err_timeout", 32'(bus.err_timeout), 32'd0);
    chk("reset n0", 32'(bus.out_n0), 32'd0);
    chk("reset opt", 32'(bus.out_opt), 32'd0);

    // Table frames; later beats carry inverted opt/equ, and out_ready toggles during gaps.
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 6; b++) begin
        beat(vecs[i].d[b], (b == 0) ? vecs[i].opt : ~vecs[i].opt,
             (b == 0) ? vecs[i].equ : ~vecs[i].equ);
        if (b == 4) chk($sformatf("vec%0d early out_valid", i), 32'(bus.out_valid), 32'd0);
        if (b < 5 && vecs[i].gap != 0) begin
          bus.out_ready = 1'b1;
          repeat (vecs[i].gap) tick();
          bus.out_ready = 1'b0;
          chk($sformatf("vec%0d gap in_ready", i), 32'(bus.in_ready), 32'd1);
        end
      end
      chk_frame($sformatf("vec%0d", i), vecs[i].e, vecs[i].eopt, vecs[i].eequ);
      chk($sformatf("vec%0d cnt before", i), 32'(bus.frame_cnt), 32'(vecs[i].ecnt - 8'd1));
      handoff();
      chk($sformatf("vec%0d cnt after", i), 32'(bus.frame_cnt), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d out_valid low", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Reset mid-frame, checked while rst is still asserted.
    beat(4'd11, 3'b001, 1'b1);
    beat(4'd12, 3'b001, 1'b1);
    beat(4'd13, 3'b001, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("midrst n0", 32'(bus.out_n0), 32'd0);
    #1 rst = 1'b0;
    tick();
    for (int b = 0; b < 6; b++) beat(4'(b + 1), 3'b110, 1'b0);
    exp6 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    chk_frame("postrst", exp6, 3'b110, 1'b0);
    handoff();
    chk("postrst cnt", 32'(bus.frame_cnt), 32'd1);

    // Backpressure with in_valid held high during HOLD.
    beat(4'd3, 3'b010, 1'b0);
    beat(4'd1, 3'b000, 1'b1);
    beat(4'd4, 3'b000, 1'b1);
    beat(4'd1, 3'b000, 1'b1);
    beat(4'd5, 3'b000, 1'b1);
    beat(4'd9, 3'b000, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd8;
    bus.in_opt   = 3'b111;
    bus.in_equ   = 1'b1;
    exp6 = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_frame($sformatf("bp%0d", c), exp6, 3'b010, 1'b0);
    end
    handoff();
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release cnt", 32'(bus.frame_cnt), 32'd2);
    chk("bp release n0 kept", 32'(bus.out_n0), 32'd3);
    tick();
    bus.in_valid = 1'b0;
    chk("bp first beat n0", 32'(bus.out_n0), 32'd8);
    chk("bp first beat n1 kept", 32'(bus.out_n1), 32'd1);
    chk("bp first beat opt", 32'(bus.out_opt), 32'd7);
    chk("bp first beat equ", 32'(bus.out_equ), 32'd1);
    async_reset();
    tick();

    // frame_cnt wrap after 256 handoffs.
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 6; b++) beat(4'(f + b), 3'b000, 1'b0);
      handoff();
      if (f == 254) chk("wrap cnt 255", 32'(bus.frame_cnt), 32'd255);
    end
    chk("wrap cnt 0", 32'(bus.frame_cnt), 32'd0);
    async_reset();
    tick();

    // Two beats then a long idle gap.
    beat(4'd5, 3'b001, 1'b0);
    beat(4'd6, 3'b001, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("gap%0d err_timeout", i), 32'(bus.err_timeout),
          32'((i == 15) ? TO_EN : 1'b0));
    end
    tick();
    chk("gap pulse ends", 32'(bus.err_timeout), 32'd0);
    chk("gap in_ready", 32'(bus.in_ready), 32'd1);
    for (int b = 0; b < 4; b++) beat(4'd4, 3'b000, 1'b0);
`ifdef CC_COLLECT_TIMEOUT_EN
    chk("to partial out_valid", 32'(bus.out_valid), 32'd0);
    beat(4'd4, 3'b000, 1'b0);
    beat(4'd4, 3'b000, 1'b0);
    exp6 = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    chk_frame("to frame", exp6, 3'b000, 1'b0);
    chk("to cnt unchanged", 32'(bus.frame_cnt), 32'd0);
`else
    exp6 = '{4'd5, 4'd6, 4'd4, 4'd4, 4'd4, 4'd4};
    chk_frame("noto frame", exp6, 3'b001, 1'b0);
`endif
    handoff();
    chk("final cnt", 32'(bus.frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/cc_frame_collector.md
Name: cc_frame_collector

Overview:
Input stage directly upstream of the combinational CC sort/normalise/equation block. Receives the six 4-bit operands serially, one per accepted beat, with the frame's opt/equ controls. Holds them in registers and presents them as one parallel frame with a valid/ready handshake. Gives CC a stable, registered operand set for the whole time its result is consumed.

Parameters:
NUM_ELEM, 6, operands per frame; CC requires exactly 6
DATA_W, 4, operand width in bits
TIMEOUT_CYC, 15, idle-gap limit in cycles inside a frame (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream beat valid
in_data  input  DATA_W  operand for the current beat
in_opt  input  3  frame option bits, sampled on the first beat only
in_equ  input  1  frame equation select, sampled on the first beat only
in_ready  output  1  collector can accept a beat
out_valid  output  1  complete frame presented
out_ready  input  1  downstream consumed the frame
out_n0..out_n5  output  DATA_W each  operands in arrival order (out_n0 = first beat)
out_opt  output  3  latched in_opt
out_equ  output  1  latched in_equ
frame_cnt  output  8  count of frames handed off, wraps 255->0
err_timeout  output  1  one-cycle pulse on a frame abort

Behaviour:
- Reset (asynchronous, any state): state=IDLE, beat index=0, out_n0..5=0, out_opt=0, out_equ=0, out_valid=0, frame_cnt=0, err_timeout=0. Any partial frame is discarded. Reset has no synchronous component.
- Accept = in_valid & in_ready. in_data is ignored on cycles without accept.
- States:
  - IDLE:
    - in_ready=1.
    - On accept: store in_data into slot 0, latch in_opt/in_equ, set idx=1, go to COLLECT.
  - COLLECT:
    - in_ready=1.
    - On accept: store in_data into slot idx, then idx+1.
    - in_opt/in_equ are not resampled.
    - On the accept with idx=NUM_ELEM-1, go to HOLD.
  - HOLD:
    - in_ready=0, out_valid=1.
    - On out_valid & out_ready: frame_cnt+1, out_valid falls next cycle, go to IDLE, idx=0.
- Latency: out_valid rises on the clock edge that captures the sixth beat. Minimum 6 cycles from first beat to out_valid. One frame per 7 cycles at full throughput.
- Output registers stay stable while out_valid=1 and out_ready=0 (no overwrite, no beat loss). Outputs keep the last frame's values after handoff until overwritten by new beats.
- out_ready while out_valid=0 has no effect.
- in_valid held high in HOLD is not accepted. The beat is taken on the first IDLE cycle.
- No combinational path from in_valid to in_ready. in_ready is a function of state only.
- frame_cnt wraps silently.
- Widths: operands are passed unmodified. Sign interpretation is left to CC via out_opt[0].

Optional Feature:
Macro CC_COLLECT_TIMEOUT_EN.
- Defined:
  - A gap counter in COLLECT clears on every accept and increments otherwise.
  - When it reaches TIMEOUT_CYC consecutive non-accept cycles, the partial frame is dropped: go to IDLE, idx=0, err_timeout=1 for exactly that cycle.
  - frame_cnt is unchanged. Slot registers are not cleared.
  - The gap counter is inactive in IDLE and HOLD. Reset clears it.
- Not defined: COLLECT waits indefinitely, err_timeout is constant 0, and no gap counter is built.

Test Plan:
1. Reset mid-frame: accept 3 beats, pulse rst asynchronously between edges -> out_valid=0, in_ready=1, frame_cnt=0 immediately. The next 6 beats 1,2,3,4,5,6 form a clean frame.
2. Back-to-back beats 9,0,15,3,7,1 with in_opt=3'b011, in_equ=1 on beat 1, and opt=0 on later beats -> out_valid on sixth edge, out_n0..5=9,0,15,3,7,1, out_opt=3'b011, out_equ=1.
3. Backpressure: frame complete, out_ready=0 for 10 cycles while in_valid=1 with data 8 -> in_ready=0, outputs unchanged. The out_ready pulse gives frame_cnt=1 and in_ready=1 next cycle.
4. Gapped input: beats with in_valid low 1–3 cycles between them (gaps <TIMEOUT_CYC) -> correct frame, arrival-ordered.
5. frame_cnt wrap: 256 frames -> frame_cnt reads 0.
6. With CC_COLLECT_TIMEOUT_EN: 2 beats then 15 idle cycles -> err_timeout high one cycle, state IDLE. The next frame 4,4,4,4,4,4 is delivered intact. Without the macro, the same stimulus stays in COLLECT and err_timeout stays 0.
